// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared timing defaults for the VGA raster generator (640x480 @ 60 Hz with
//   a 25.175 MHz pixel clock) and the coordinate type used by every consumer
//   of DrawX/DrawY.
//   Contents:
//     DEF_H_* / DEF_V_*  default porch/sync/visible widths
//     DEF_H_TOTAL/V_TOTAL derived line and frame lengths
//     coord_t            10-bit pixel coordinate (covers totals up to 1024)
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_FC_W = 8;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter
//   Modulo-(MAX+1) up counter used for the raster X and Y axes.
//   Reset parks the count on MAX so the first enabled step lands on 0.
//   Ports:
//     vga_clk  in   pixel clock, state on posedge
//     reset_n  in   asynchronous active-low reset (count -> MAX)
//     en       in   advance by one this cycle
//     clr      in   synchronous clear to 0 (has priority over en)
//     q        out  current count
//     q_next   out  value q will take at the next clock edge
//     wrap     out  en is high and q is at MAX (q_next is the wrap to 0)
module wrap_counter
  import vga_pkg::*;
#(
  parameter int MAX = DEF_H_TOTAL - 1
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   en,
  input  logic   clr,
  output coord_t q,
  output coord_t q_next,
  output logic   wrap
);

  coord_t q_reg;
  coord_t q_next_w;

  assign wrap = en && (q_reg == coord_t'(MAX));

  always_comb begin
    q_next_w = q_reg;
    if (clr) begin
      q_next_w = '0;
    end else if (en) begin
      q_next_w = wrap ? '0 : q_reg + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= coord_t'(MAX);
    end else begin
      q_reg <= q_next_w;
    end
  end

  assign q      = q_reg;
  assign q_next = q_next_w;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator: sync pulses, active-video flag, current pixel
//   coordinate, per-line / per-frame strobes and a frame counter for sprite
//   animation sequencing.
//   Ports:
//     vga_clk      in   pixel clock, all state on posedge
//     reset_n      in   asynchronous active-low reset
//     ce           in   pixel advance enable
//     hs, vs       out  horizontal / vertical sync, active low
//     blank        out  1 = visible pixel, 0 = porch or sync
//     DrawX, DrawY out  current column / row
//     line_start   out  one-cycle pulse when DrawX becomes 0
//     frame_start  out  one-cycle pulse when (DrawX,DrawY) becomes (0,0)
//     frame_count  out  completed-frame counter, wraps silently
//   Every output is a register. hs/vs/blank are loaded from a decode of the
//   counters' next value, so they line up with DrawX/DrawY in the same cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int FC_W      = DEF_FC_W
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  input  logic            ce,
  output logic            hs,
  output logic            vs,
  output logic            blank,
  output coord_t          DrawX,
  output coord_t          DrawY,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_timing_check
    $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed the 10-bit coordinate range",
           H_TOTAL, V_TOTAL);
  end

  // Decode boundaries held in 11 bits so porch sums near 1024 cannot overflow.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t x_q, x_next, y_q, y_next;
  logic   h_wrap, v_wrap;

  wrap_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .en      (ce),
    .clr     (1'b0),
    .q       (x_q),
    .q_next  (x_next),
    .wrap    (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .en      (ce && h_wrap),
    .clr     (1'b0),
    .q       (y_q),
    .q_next  (y_next),
    .wrap    (v_wrap)
  );

  logic [10:0] x_ext, y_ext;
  logic        hs_next, vs_next, blank_next;
  logic        line_start_next, frame_start_next;

  always_comb begin
    x_ext      = {1'b0, x_next};
    y_ext      = {1'b0, y_next};
    blank_next = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
    hs_next    = !((x_ext >= HS_START) && (x_ext < HS_END));
    vs_next    = !((y_ext >= VS_START) && (y_ext < VS_END));
    // The counters only reach 0 through a wrap, so the wrap flags are exactly
    // "ce and next X == 0" and "ce and next (X,Y) == (0,0)".
    line_start_next  = h_wrap;
    frame_start_next = v_wrap;
  end

  logic            hs_reg, vs_reg, blank_reg;
  logic            line_start_reg, frame_start_reg;
  logic [FC_W-1:0] frame_count_reg;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      blank_reg       <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      // All ones, so the first frame after reset reads back as frame 0.
      frame_count_reg <= '1;
    end else if (ce) begin
      hs_reg          <= hs_next;
      vs_reg          <= vs_next;
      blank_reg       <= blank_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      if (frame_start_next) begin
        frame_count_reg <= frame_count_reg + FC_W'(1);
      end
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign blank       = blank_reg;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two instances: the default 640x480 timing for line-level checks, and a
//   tiny 16x8 raster so multi-frame behaviour fits in a short run. A raster
//   model predicts every output of both instances each cycle; the prediction
//   is queued when ce is driven and compared after the clock edge.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs, vs, blank, ls, fs;
    logic [9:0] x, y;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int hv, hf, hsy, hb, vv, vf, vsy, vb;
  } tim_t;

  typedef struct {
    logic       ce;
    logic [9:0] x, y;
    logic       blank, ls, fs;
    logic [7:0] fc;
  } vec_t;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b1;
  logic ce      = 1'b0;

  always #5 vga_clk = ~vga_clk;

  logic       d_hs, d_vs, d_blank, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  vga_timing_gen u_dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .hs          (d_hs),
    .vs          (d_vs),
    .blank       (d_blank),
    .DrawX       (d_x),
    .DrawY       (d_y),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .FC_W(8)
  ) u_small (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .hs          (s_hs),
    .vs          (s_vs),
    .blank       (s_blank),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;
  tim_t t_big, t_small;
  obs_t m_big, m_small;
  obs_t q_big[$];
  obs_t q_small[$];
  vec_t tbl[6];

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
      if (failures >= 50) finish_tb();
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got hs=%b vs=%b blank=%b ls=%b fs=%b x=%0d y=%0d fc=%0d expected hs=%b vs=%b blank=%b ls=%b fs=%b x=%0d y=%0d fc=%0d",
               name, cyc_n, act.hs, act.vs, act.blank, act.ls, act.fs, act.x, act.y, act.fc,
               exp.hs, exp.vs, exp.blank, exp.ls, exp.fs, exp.x, exp.y, exp.fc);
      if (failures >= 50) finish_tb();
    end
  endtask

  function automatic obs_t d_obs();
    return {d_hs, d_vs, d_blank, d_ls, d_fs, d_x, d_y, d_fc};
  endfunction

  function automatic obs_t s_obs();
    return {s_hs, s_vs, s_blank, s_ls, s_fs, s_x, s_y, s_fc};
  endfunction

  function automatic obs_t reset_obs(input tim_t t);
    obs_t r;
    r.hs    = 1'b1;
    r.vs    = 1'b1;
    r.blank = 1'b0;
    r.ls    = 1'b0;
    r.fs    = 1'b0;
    r.x     = 10'(t.hv + t.hf + t.hsy + t.hb - 1);
    r.y     = 10'(t.vv + t.vf + t.vsy + t.vb - 1);
    r.fc    = 8'hFF;
    return r;
  endfunction

  function automatic obs_t model_step(input obs_t s, input logic c, input tim_t t);
    obs_t n;
    int   ht, vt, nx, ny;
    ht   = t.hv + t.hf + t.hsy + t.hb;
    vt   = t.vv + t.vf + t.vsy + t.vb;
    nx   = int'(s.x);
    ny   = int'(s.y);
    n    = s;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (c) begin
      if (nx == ht - 1) begin
        nx = 0;
        ny = (ny == vt - 1) ? 0 : ny + 1;
      end else begin
        nx = nx + 1;
      end
      n.x     = 10'(nx);
      n.y     = 10'(ny);
      n.blank = (nx < t.hv) && (ny < t.vv);
      n.hs    = !((nx >= t.hv + t.hf) && (nx < t.hv + t.hf + t.hsy));
      n.vs    = !((ny >= t.vv + t.vf) && (ny < t.vv + t.vf + t.vsy));
      n.ls    = (nx == 0);
      n.fs    = (nx == 0) && (ny == 0);
      if (n.fs) n.fc = s.fc + 8'd1;
    end
    return n;
  endfunction

  // One pixel-clock transaction: drive ce, queue the prediction, compare.
  task automatic cyc(input logic c);
    ce = c;
    m_big   = model_step(m_big, c, t_big);
    m_small = model_step(m_small, c, t_small);
    q_big.push_back(m_big);
    q_small.push_back(m_small);
    @(posedge vga_clk);
    #1;
    cyc_n++;
    chk_obs("sb_big", d_obs(), q_big.pop_front());
    chk_obs("sb_small", s_obs(), q_small.pop_front());
  endtask

  // Asynchronous assert (checked before any clock edge), release away from the edge.
  task automatic do_reset();
    ce      = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_obs("async_rst_big", d_obs(), reset_obs(t_big));
    chk_obs("async_rst_small", s_obs(), reset_obs(t_small));
    m_big   = reset_obs(t_big);
    m_small = reset_obs(t_small);
    q_big.delete();
    q_small.delete();
    repeat (2) @(posedge vga_clk);
    #1;
    chk_obs("held_rst_big", d_obs(), reset_obs(t_big));
    reset_n = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected completion", cyc_n);
    failures++;
    finish_tb();
  end

  initial begin
    int hs_low, blank_low, ls_cnt, hmin, hmax, guard, cnt, vs_low, lsc, ls_wide;
    logic prev_ls;
    int fs_t[$];
    int ls_t[$];

    t_big   = '{640, 16, 96, 48, 480, 10, 2, 33};
    t_small = '{8, 2, 3, 3, 4, 1, 2, 1};

    tbl[0] = '{1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[1] = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{1'b1, 10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 10'd3, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};

    #2;
    do_reset();
    chk("rst_x", int'(d_x), 799);
    chk("rst_y", int'(d_y), 524);
    chk("rst_hs", int'(d_hs), 1);
    chk("rst_vs", int'(d_vs), 1);
    chk("rst_blank", int'(d_blank), 0);
    chk("rst_ls", int'(d_ls), 0);
    chk("rst_fs", int'(d_fs), 0);
    chk("rst_fc", int'(d_fc), 255);
    cyc(1'b0);
    cyc(1'b0);
    $display("TXN reset: x=%0d y=%0d fc=%0d", d_x, d_y, d_fc);

    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].ce);
      chk($sformatf("tbl%0d_x", i), int'(d_x), int'(tbl[i].x));
      chk($sformatf("tbl%0d_y", i), int'(d_y), int'(tbl[i].y));
      chk($sformatf("tbl%0d_blank", i), int'(d_blank), int'(tbl[i].blank));
      chk($sformatf("tbl%0d_ls", i), int'(d_ls), int'(tbl[i].ls));
      chk($sformatf("tbl%0d_fs", i), int'(d_fs), int'(tbl[i].fs));
      chk($sformatf("tbl%0d_fc", i), int'(d_fc), int'(tbl[i].fc));
      $display("TXN vector %0d: ce=%b x=%0d y=%0d fs=%b fc=%0d", i, tbl[i].ce, d_x, d_y, d_fs, d_fc);
    end

    // Two full lines from (3,0): hsync and blanking widths and positions.
    hs_low = 0; blank_low = 0; ls_cnt = 0; hmin = 1023; hmax = 0;
    repeat (1600) begin
      cyc(1'b1);
      if (!d_hs) begin
        hs_low++;
        if (int'(d_x) < hmin) hmin = int'(d_x);
        if (int'(d_x) > hmax) hmax = int'(d_x);
      end
      if (!d_blank) blank_low++;
      if (d_ls) ls_cnt++;
    end
    chk("hs_low_cycles", hs_low, 192);
    chk("hs_first_x", hmin, 656);
    chk("hs_last_x", hmax, 751);
    chk("blank_low_cycles", blank_low, 320);
    chk("line_start_count", ls_cnt, 2);
    $display("TXN two lines: hs_low=%0d blank_low=%0d ls=%0d", hs_low, blank_low, ls_cnt);

    // Walk to a mid-frame position, then reset there.
    guard = 0;
    while (!((d_x == 10'd300) && (d_y == 10'd10)) && (guard < 20000)) begin
      cyc(1'b1);
      guard++;
    end
    chk("reach_mid_frame", int'(guard < 20000), 1);
    $display("TXN mid-frame reset at x=%0d y=%0d", d_x, d_y);
    do_reset();
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    chk("post_rst_x", int'(d_x), 0);
    chk("post_rst_y", int'(d_y), 0);
    chk("post_rst_fs", int'(d_fs), 1);
    chk("post_rst_fc", int'(d_fc), 0);

    // ce alternating 1,0: frame and line periods double.
    ls_wide = 0;
    prev_ls = 1'b0;
    for (int i = 0; i < 3400; i++) begin
      cyc((i % 2) == 0);
      if (s_fs) fs_t.push_back(cyc_n);
      if (d_ls) ls_t.push_back(cyc_n);
      if (prev_ls && d_ls) ls_wide++;
      prev_ls = d_ls;
    end
    chk("toggle_fs_pulses", int'(fs_t.size() >= 3), 1);
    if (fs_t.size() >= 3) begin
      chk("toggle_frame_period_a", fs_t[1] - fs_t[0], 256);
      chk("toggle_frame_period_b", fs_t[2] - fs_t[1], 256);
    end
    chk("toggle_ls_pulses", int'(ls_t.size() >= 2), 1);
    if (ls_t.size() >= 2) chk("toggle_line_period", ls_t[1] - ls_t[0], 1600);
    chk("toggle_ls_wide", ls_wide, 0);
    $display("TXN ce toggle: frames=%0d lines=%0d", fs_t.size(), ls_t.size());

    // 257 frames of the small raster from reset: frame_count 255 then wrap.
    do_reset();
    cnt = 0; vs_low = 0; lsc = 0;
    fs_t.delete();
    repeat (257 * 128) begin
      cyc(1'b1);
      if (s_fs) begin
        cnt++;
        fs_t.push_back(cyc_n);
        if (cnt == 1) chk("fc_first", int'(s_fc), 0);
        if (cnt == 256) chk("fc_255", int'(s_fc), 255);
        if (cnt == 257) chk("fc_wrap", int'(s_fc), 0);
      end
      if (!s_vs) vs_low++;
      if (s_ls) lsc++;
    end
    chk("frame_count_pulses", cnt, 257);
    chk("vs_low_cycles", vs_low, 257 * 32);
    chk("line_start_total", lsc, 257 * 8);
    if (fs_t.size() >= 2) chk("frame_period", fs_t[1] - fs_t[0], 128);
    $display("TXN 257 frames: fs=%0d vs_low=%0d ls=%0d fc=%0d", cnt, vs_low, lsc, s_fc);

    finish_tb();
  end

endmodule
